// File: rtl/nw_align_emitter_pkg.sv
// Shared types for the Needleman-Wunsch alignment emitter: FSM states,
// traceback step classes and alignment-column packing helpers.
package nw_align_emitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_TERM,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    STEP_DIAG,
    STEP_UP,
    STEP_LEFT,
    STEP_BAD
  } step_e;

  localparam int unsigned COORD_MAX_W = 16;

  // Column layout is {gap1, c1, gap2, c2}.
  function automatic int unsigned col_width(input int unsigned cwidth);
    return 2 * cwidth + 2;
  endfunction

  // Classifies the move from prev (px,py) to cur (cx,cy); widened sums avoid wrap at zero.
  function automatic step_e classify_step(input logic [COORD_MAX_W-1:0] px,
                                          input logic [COORD_MAX_W-1:0] py,
                                          input logic [COORD_MAX_W-1:0] cx,
                                          input logic [COORD_MAX_W-1:0] cy);
    logic [COORD_MAX_W:0] cx1;
    logic [COORD_MAX_W:0] cy1;
    logic [COORD_MAX_W:0] pxw;
    logic [COORD_MAX_W:0] pyw;
    cx1 = {1'b0, cx} + 1'b1;
    cy1 = {1'b0, cy} + 1'b1;
    pxw = {1'b0, px};
    pyw = {1'b0, py};
    if (cx1 == pxw && cy1 == pyw)     return STEP_DIAG;
    else if (cx == px && cy1 == pyw)  return STEP_UP;
    else if (cx1 == pxw && cy == py)  return STEP_LEFT;
    else                              return STEP_BAD;
  endfunction

endpackage

// File: rtl/nw_align_emitter_column_lifo.sv
// Parameterised stack of alignment columns; push on full and pop on empty
// are ignored and reported through the overflow/underflow flags.
module nw_column_lifo #(
  parameter int unsigned DEPTH = 19,
  parameter int unsigned WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             push_ok, pop_ok;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    push_ok   = push && !full && !clear;
    pop_ok    = pop && !empty && !push && !clear;
    overflow  = push && full;
    underflow = pop && empty;
    wr_idx    = AW'(count_q);
    rd_idx    = AW'(count_q - CW'(1));
    count_d   = count_q;
    if (clear)        count_d = '0;
    else if (push_ok) count_d = count_q + CW'(1);
    else if (pop_ok)  count_d = count_q - CW'(1);
    top   = empty ? '0 : mem_q[rd_idx];
    count = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/nw_align_emitter.sv
// Converts the Needleman-Wunsch traceback coordinate stream into alignment
// columns, stacks them and replays them in forward order over valid/ready.
module nw_align_emitter
  import nw_align_emitter_pkg::*;
#(
  parameter int unsigned LENGTH      = 10,
  parameter int unsigned CWIDTH      = 2,
  parameter int unsigned CORD_LENGTH = 8,
  parameter int unsigned DEPTH       = 2 * LENGTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CORD_LENGTH-1:0]     in_x,
  input  logic [CORD_LENGTH-1:0]     in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CWIDTH-1:0]          out_c1,
  output logic [CWIDTH-1:0]          out_c2,
  output logic                       out_gap1,
  output logic                       out_gap2,
  output logic                       out_last,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned COL_W = col_width(CWIDTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CORD_LENGTH-1:0] LAST = CORD_LENGTH'(LENGTH - 1);

  state_e                    state_q, state_d;
  logic [LENGTH*CWIDTH-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [CORD_LENGTH-1:0]    prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic                      first_q, first_d;

  logic                      lifo_clear, lifo_push, lifo_pop;
  logic [COL_W-1:0]          lifo_wdata, lifo_top;
  logic [CNT_W-1:0]          lifo_count;
  logic                      lifo_full, lifo_empty, lifo_overflow, lifo_underflow;
  step_e                     step;
  logic [CWIDTH-1:0]         ch1, ch2;

  function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                input logic [CORD_LENGTH-1:0]   idx);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int unsigned j = 0; j < LENGTH; j++) begin
      if (idx == CORD_LENGTH'(j)) c = s[(LENGTH-1-j)*CWIDTH +: CWIDTH];
    end
    return c;
  endfunction

  nw_column_lifo #(
    .DEPTH (DEPTH),
    .WIDTH (COL_W)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (lifo_clear),
    .push      (lifo_push),
    .push_data (lifo_wdata),
    .pop       (lifo_pop),
    .top       (lifo_top),
    .count     (lifo_count),
    .full      (lifo_full),
    .empty     (lifo_empty),
    .overflow  (lifo_overflow),
    .underflow (lifo_underflow)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      prev_x_q <= '0;
      prev_y_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      first_q  <= first_d;
    end
  end

  // Latched strings survive reset; they only matter after the next start.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  always_comb begin
    state_d    = state_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    first_d    = first_q;
    lifo_clear = 1'b0;
    lifo_push  = 1'b0;
    lifo_pop   = 1'b0;
    lifo_wdata = '0;
    step = classify_step(COORD_MAX_W'(prev_x_q), COORD_MAX_W'(prev_y_q),
                         COORD_MAX_W'(in_x), COORD_MAX_W'(in_y));
    ch1  = char_at(s1_q, prev_y_q);
    ch2  = char_at(s2_q, prev_x_q);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          s1_d       = s1;
          s2_d       = s2;
          lifo_clear = 1'b1;
          first_d    = 1'b1;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          if (in_x > LAST || in_y > LAST) begin
            state_d = ST_ERR;
          end else if (first_q) begin
            if (in_x == LAST && in_y == LAST) begin
              prev_x_d = in_x;
              prev_y_d = in_y;
              first_d  = 1'b0;
            end else begin
              state_d = ST_ERR;
            end
          end else if (step == STEP_BAD) begin
            state_d = ST_ERR;
          end else begin
            lifo_push = 1'b1;
            unique case (step)
              STEP_DIAG: lifo_wdata = {1'b0, ch1, 1'b0, ch2};
              STEP_UP:   lifo_wdata = {1'b0, ch1, 1'b1, {CWIDTH{1'b0}}};
              default:   lifo_wdata = {1'b1, {CWIDTH{1'b0}}, 1'b0, ch2};
            endcase
            prev_x_d = in_x;
            prev_y_d = in_y;
            if (lifo_overflow)                 state_d = ST_ERR;
            else if (in_x == '0 && in_y == '0) state_d = ST_TERM;
          end
        end
      end
      ST_TERM: begin
        if (lifo_full) begin
          state_d = ST_ERR;
        end else begin
          lifo_push  = 1'b1;
          lifo_wdata = {1'b0, char_at(s1_q, '0), 1'b0, char_at(s2_q, '0)};
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        lifo_pop = !lifo_empty && out_ready;
        if (lifo_underflow)                                state_d = ST_ERR;
        else if (lifo_pop && lifo_count == CNT_W'(1))      state_d = ST_DONE;
      end
      default: state_d = ST_ERR;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_COLLECT);
    out_valid = (state_q == ST_EMIT) && !lifo_empty;
    out_gap1  = out_valid & lifo_top[COL_W-1];
    out_c1    = out_valid ? lifo_top[COL_W-2 -: CWIDTH] : '0;
    out_gap2  = out_valid & lifo_top[CWIDTH];
    out_c2    = out_valid ? lifo_top[CWIDTH-1:0] : '0;
    out_last  = out_valid && (lifo_count == CNT_W'(1));
    done      = (state_q == ST_DONE);
    error     = (state_q == ST_ERR);
  end

endmodule

// File: tb/tb_nw_align_emitter.sv
// Directed bench for nw_align_emitter with LENGTH=4: forward column order,
// gap columns, stalls, malformed paths, reset mid-stream and back-to-back runs.
module tb_nw_align_emitter;

  localparam int unsigned L  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned CL = 8;

  localparam logic [1:0] A = 2'd0, C = 2'd1, G = 2'd2, T = 2'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [L*CW-1:0] s1 = '0, s2 = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CL-1:0] in_x = '0, in_y = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_c1, out_c2;
  logic          out_gap1, out_gap2, out_last, done, error;

  int checks = 0;
  int errors = 0;

  logic [CL-1:0]     cx [8];
  logic [CL-1:0]     cy [8];
  logic [2*CW+1:0]   exp_col [8];

  nw_align_emitter #(
    .LENGTH      (L),
    .CWIDTH      (CW),
    .CORD_LENGTH (CL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s1        (s1),
    .s2        (s2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c1    (out_c1),
    .out_c2    (out_c2),
    .out_gap1  (out_gap1),
    .out_gap2  (out_gap2),
    .out_last  (out_last),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic logic [2*CW+1:0] pair(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a, 1'b0, b};
  endfunction
  function automatic logic [2*CW+1:0] gap2(input logic [1:0] a);
    return {1'b0, a, 1'b1, 2'b00};
  endfunction
  function automatic logic [2*CW+1:0] gap1(input logic [1:0] b);
    return {1'b1, 2'b00, 1'b0, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick;
  endtask

  task automatic start_run(input logic [L*CW-1:0] a, input logic [L*CW-1:0] b);
    s1 = a; s2 = b; start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_collect: in_ready=%b done=%b, want in_ready=1 done=0", in_ready, done);
    end
  endtask

  task automatic send_coords(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_x = cx[i]; in_y = cy[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL coord_ready[%0d]: in_ready=%b, want 1", i, in_ready);
      end
      tick;
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL term_state: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
    end
    tick;
  endtask

  task automatic emit_check(input int n, input bit rnd, input int stop_after);
    int idx = 0;
    int budget = 0;
    bit stalled = 1'b0;
    logic [2*CW+1:0] held = '0;
    logic [2*CW+1:0] obs;
    while (idx < n && idx != stop_after && budget < 200) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      obs = {out_gap1, out_c1, out_gap2, out_c2};
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL emit_valid[%0d]: out_valid=%b, want 1", idx, out_valid);
      end else begin
        if (obs !== exp_col[idx]) begin
          errors++;
          $display("FAIL column[%0d]: got %b, want %b", idx, obs, exp_col[idx]);
        end
        checks++;
        if (out_last !== 1'(idx == n - 1)) begin
          errors++;
          $display("FAIL out_last[%0d]: got %b, want %b", idx, out_last, 1'(idx == n - 1));
        end
        if (stalled) begin
          checks++;
          if (obs !== held) begin
            errors++;
            $display("FAIL hold[%0d]: got %b, want %b", idx, obs, held);
          end
        end
      end
      stalled = out_valid && !out_ready;
      held = obs;
      if (out_valid && out_ready) idx++;
      tick;
      budget++;
    end
    out_ready = 1'b0;
    if (budget >= 200) begin
      checks++; errors++;
      $display("FAIL emit_timeout: popped %0d of %0d columns", idx, n);
    end else if (idx == n) begin
      checks++;
      if (done !== 1'b1 || out_valid !== 1'b0 || error !== 1'b0) begin
        errors++;
        $display("FAIL done: done=%b out_valid=%b error=%b, want 1 0 0", done, out_valid, error);
      end
    end
  endtask

  task automatic load_diag_path;
    for (int i = 0; i < 4; i++) begin
      cx[i] = CL'(3 - i);
      cy[i] = CL'(3 - i);
    end
  endtask

  task automatic load_gap_path;
    cx[0] = 8'd3; cy[0] = 8'd3;
    cx[1] = 8'd2; cy[1] = 8'd3;
    cx[2] = 8'd1; cy[2] = 8'd2;
    cx[3] = 8'd0; cy[3] = 8'd1;
    cx[4] = 8'd0; cy[4] = 8'd0;
    exp_col[0] = pair(A, C);
    exp_col[1] = gap2(C);
    exp_col[2] = pair(G, G);
    exp_col[3] = pair(T, T);
    exp_col[4] = gap1(A);
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({in_ready, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b, want all 0",
               {in_ready, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last, done, error});
    end
  endtask

  task automatic test_diag_path;
    do_reset;
    load_diag_path;
    exp_col[0] = pair(A, A); exp_col[1] = pair(C, C);
    exp_col[2] = pair(G, G); exp_col[3] = pair(T, T);
    start_run(8'h1B, 8'h1B);
    send_coords(4);
    emit_check(4, 1'b0, -1);
  endtask

  task automatic test_gap_path;
    do_reset;
    load_gap_path;
    start_run(8'h1B, 8'h6C);
    send_coords(5);
    emit_check(5, 1'b0, -1);
  endtask

  task automatic test_random_ready;
    do_reset;
    load_gap_path;
    start_run(8'h1B, 8'h6C);
    send_coords(5);
    emit_check(5, 1'b1, -1);
  endtask

  task automatic test_errors;
    do_reset;
    start_run(8'h1B, 8'h1B);
    in_valid = 1'b1; in_x = 8'd2; in_y = 8'd3;
    tick;
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_first: error=%b in_ready=%b out_valid=%b, want 1 0 0", error, in_ready, out_valid);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL error_sticky: error=%b in_ready=%b done=%b, want 1 0 0", error, in_ready, done);
    end

    do_reset;
    start_run(8'h1B, 8'h1B);
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3;
    tick;
    in_y = 8'd1;
    tick;
    in_valid = 1'b0;
    repeat (2) tick;
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_step: error=%b in_ready=%b out_valid=%b, want 1 0 0", error, in_ready, out_valid);
    end

    do_reset;
    start_run(8'h1B, 8'h1B);
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3;
    tick;
    in_x = 8'd4; in_y = 8'd2;
    tick;
    in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL coord_range: error=%b in_ready=%b, want 1 0", error, in_ready);
    end
  endtask

  task automatic test_reset_mid_emit;
    do_reset;
    load_gap_path;
    start_run(8'h1B, 8'h6C);
    send_coords(5);
    emit_check(5, 1'b0, 2);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_mid_emit: outputs=%b, want all 0",
               {in_ready, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last, done, error});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b1; in_x = 8'd3; in_y = 8'd3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_not_ready: in_ready=%b, want 0", in_ready);
    end
    tick;
    in_valid = 1'b0;
    load_diag_path;
    exp_col[0] = pair(A, A); exp_col[1] = pair(C, C);
    exp_col[2] = pair(G, G); exp_col[3] = pair(T, T);
    start_run(8'h1B, 8'h1B);
    send_coords(4);
    emit_check(4, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    do_reset;
    load_diag_path;
    exp_col[0] = pair(A, A); exp_col[1] = pair(C, C);
    exp_col[2] = pair(G, G); exp_col[3] = pair(T, T);
    start_run(8'h1B, 8'h1B);
    send_coords(4);
    emit_check(4, 1'b0, -1);
    // s1 = T,G,C,A and s2 = C,G,T,A along the same diagonal path
    exp_col[0] = pair(T, C); exp_col[1] = pair(G, G);
    exp_col[2] = pair(C, T); exp_col[3] = pair(A, A);
    start_run(8'hE4, 8'h6C);
    send_coords(4);
    emit_check(4, 1'b1, -1);
  endtask

  initial begin
    test_reset;
    test_diag_path;
    test_gap_path;
    test_random_ready;
    test_errors;
    test_reset_mid_emit;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
